// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side adapter for the async FIFO.
// Issues fifo_rd_en in the rd_clk domain and absorbs the FIFO's one-cycle
// registered read latency in a 2-entry skid buffer. The words leave as a
// valid/ready stream at up to one word per cycle.
// Optional feature macro: FIFO_RD_STREAM_COUNT_EN adds the rd_beat_count
// delivered-word counter port.
module fifo_rd_stream #(
  parameter int unsigned data_width  = 8,
  parameter int unsigned count_width = 16
) (
  input  logic                   rd_clk,
  input  logic                   rd_reset,
  input  logic                   fifo_empty,
  input  logic [data_width-1:0]  fifo_data,
  output logic                   fifo_rd_en,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [data_width-1:0]  m_data
`ifdef FIFO_RD_STREAM_COUNT_EN
  ,
  output logic [count_width-1:0] rd_beat_count
`endif
);

  logic [1:0]            r_occ;       // words held in head/tail (0..2)
  logic                  r_inflight;  // read issued last cycle, fifo_data valid now
  logic                  r_valid;     // registered copy of (occ != 0)
  logic [data_width-1:0] r_head;      // oldest word, drives m_data
  logic [data_width-1:0] r_tail;      // second word

  logic                  w_pop;
  logic                  w_push;
  logic [2:0]            w_space;
  logic [1:0]            w_occ_next;

  // Pop/push decode, free-slot count and the read request.
  // NOTE: every signal is assigned unconditionally here, so there is no path
  // that leaves one unassigned and no latch can be inferred.
  always_comb begin
    w_pop      = r_valid & m_ready;
    w_push     = r_inflight;
    // A slot freed by this cycle's pop can be refilled by a read issued now,
    // because that read's data only lands next cycle.
    w_space    = 3'd2 - {1'b0, r_occ} - {2'b00, r_inflight} + {2'b00, w_pop};
    w_occ_next = r_occ + {1'b0, w_push} - {1'b0, w_pop};
    fifo_rd_en = !rd_reset && !fifo_empty && (w_space != 3'd0);
  end

  assign m_valid = r_valid;
  assign m_data  = r_head;

  // Occupancy, in-flight flag and registered valid.
  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge rd_clk) begin
    if (rd_reset) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_occ      <= w_occ_next;
      r_inflight <= fifo_rd_en;
      r_valid    <= (w_occ_next != 2'd0);
    end
  end

  // Skid buffer data: the arriving word goes to the first free slot, a pop
  // shifts tail into head.
  // NOTE: the two data registers are cleared on reset because m_data must
  // read as zero after reset; larger storage would normally be left unreset.
  always_ff @(posedge rd_clk) begin
    if (rd_reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_head <= fifo_data;
          else               r_tail <= fifo_data;
        end
        2'b01: r_head <= r_tail;
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_head <= fifo_data;
          end else begin
            r_head <= r_tail;
            r_tail <= fifo_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_RD_STREAM_COUNT_EN
  logic [count_width-1:0] r_beat_count;

  // Delivered-word counter, wraps modulo 2**count_width.
  always_ff @(posedge rd_clk) begin
    if (rd_reset)   r_beat_count <= '0;
    else if (w_pop) r_beat_count <= r_beat_count + 1'b1;
  end

  assign rd_beat_count = r_beat_count;
`endif

  // Buffered plus in-flight words can never exceed the two slots.
  a_occ_bound: assert property (@(posedge rd_clk) disable iff (rd_reset)
    ({1'b0, r_occ} + {2'b00, r_inflight}) <= 3'd2);

  // A read is never requested from an empty FIFO.
  a_no_read_empty: assert property (@(posedge rd_clk)
    !(fifo_rd_en && fifo_empty));

  // The counter width must be usable when the counter is built.
  a_count_width: assert property (@(posedge rd_clk) count_width > 0);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream. The source FIFO is a queue with a one-cycle
// registered read; the reference is the word order written into that queue
// plus the rule that a word read in cycle t is visible from cycle t+2.
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int CW = 3;

  logic          clk;
  logic          rd_reset;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
`ifdef FIFO_RD_STREAM_COUNT_EN
  logic [CW-1:0] rd_beat_count;
`endif

  fifo_rd_stream #(.data_width(DW), .count_width(CW)) dut (
    .rd_clk       (clk),
    .rd_reset     (rd_reset),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_rd_en   (fifo_rd_en),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data)
`ifdef FIFO_RD_STREAM_COUNT_EN
    ,
    .rd_beat_count(rd_beat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            vectors     = 0;
  int            miscompares = 0;
  int            cyc         = 0;
  int            beats       = 0;
  int            test_pops   = 0;
  int            first_pop   = 0;
  int            last_pop    = 0;
  logic [DW-1:0] src_q[$];   // words still inside the FIFO
  logic [DW-1:0] exp_q[$];   // words read from the FIFO, not yet delivered
  logic          prev_rd     = 1'b0;
  logic          hold_pend   = 1'b0;
  logic [DW-1:0] hold_data   = '0;
  logic          s_rd;
  logic          s_valid;
  logic [DW-1:0] s_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    src_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock cycle: sample and check at the falling edge, then advance the
  // FIFO model just after the rising edge.
  task automatic tick();
    logic          pop;
    logic [DW-1:0] w;
    @(negedge clk);
    s_rd    = fifo_rd_en;
    s_valid = m_valid;
    s_data  = m_data;
    pop     = 1'b0;
    if (rd_reset) begin
      check("rd_en_in_reset", {31'd0, s_rd}, 32'd0);
    end else begin
      pop = s_valid && m_ready;
      if (fifo_empty) check("rd_en_while_empty", {31'd0, s_rd}, 32'd0);
      check("m_valid_model", {31'd0, s_valid}, {31'd0, exp_q.size() > (prev_rd ? 1 : 0)});
      if (hold_pend) check("m_data_hold", {24'd0, s_data}, {24'd0, hold_data});
      if (pop) begin
        if (exp_q.size() == 0) begin
          check("pop_without_word", 32'd1, 32'd0);
        end else begin
          check("m_data_order", {24'd0, s_data}, {24'd0, exp_q[0]});
          void'(exp_q.pop_front());
        end
        if (test_pops == 0) first_pop = cyc;
        last_pop = cyc;
        test_pops++;
        beats++;
      end
      hold_pend = s_valid && !m_ready;
      hold_data = s_data;
    end
    @(posedge clk);
    #1;
    if (rd_reset) begin
      src_q.delete();
      exp_q.delete();
      prev_rd   = 1'b0;
      hold_pend = 1'b0;
      beats     = 0;
      check("reset_m_valid", {31'd0, m_valid}, 32'd0);
      check("reset_m_data", {24'd0, m_data}, 32'd0);
`ifdef FIFO_RD_STREAM_COUNT_EN
      check("reset_count", {29'd0, rd_beat_count}, 32'd0);
`endif
    end else begin
      if (s_rd) begin
        if (src_q.size() == 0) begin
          check("read_from_empty", 32'd1, 32'd0);
        end else begin
          w = src_q.pop_front();
          fifo_data = w;
          exp_q.push_back(w);
        end
      end
      prev_rd = s_rd;
      check("occ_plus_inflight_le2", {31'd0, exp_q.size() <= 2}, 32'd1);
`ifdef FIFO_RD_STREAM_COUNT_EN
      check("beat_count", {29'd0, rd_beat_count}, beats % (1 << CW));
`endif
      fifo_empty = (src_q.size() == 0);
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rd_reset   = 1'b1;
    fifo_empty = 1'b0;
    repeat (n) tick();
    rd_reset   = 1'b0;
    fifo_empty = (src_q.size() == 0);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    m_ready = 1'b1;
    while ((src_q.size() + exp_q.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", src_q.size() + exp_q.size(), 32'd0);
  endtask

  initial begin
    rd_reset   = 1'b1;
    fifo_empty = 1'b0;
    fifo_data  = '0;
    m_ready    = 1'b0;

    // Reset held two cycles with the FIFO reporting data.
    do_reset(2);

    // Single word: request at t, visible for exactly one cycle at t+2.
    m_ready = 1'b1;
    push_word(8'hA5);
    tick();
    check("single_rd_en_t", {31'd0, s_rd}, 32'd1);
    tick();
    check("single_rd_en_t1", {31'd0, s_rd}, 32'd0);
    check("single_valid_t1", {31'd0, s_valid}, 32'd0);
    tick();
    check("single_valid_t2", {31'd0, s_valid}, 32'd1);
    check("single_data_t2", {24'd0, s_data}, 32'hA5);
    tick();
    check("single_valid_t3", {31'd0, s_valid}, 32'd0);

    // Streaming: 16 words on 16 consecutive cycles.
    test_pops = 0;
    for (int i = 0; i < 16; i++) push_word(DW'(i));
    drain(60);
    check("stream_count", test_pops, 32'd16);
    check("stream_no_gaps", last_pop - first_pop, 32'd15);

    // Backpressure: consumer stalls for cycles 3..8.
    test_pops = 0;
    for (int i = 0; i < 8; i++) push_word(DW'(8'h10 + i));
    for (int i = 0; i < 12; i++) begin
      m_ready = !(i >= 3 && i <= 8);
      tick();
    end
    drain(60);
    check("backpressure_count", test_pops, 32'd8);

    // Underflow: only three words available.
    test_pops = 0;
    for (int i = 0; i < 3; i++) push_word(DW'(8'h30 + i));
    m_ready = 1'b1;
    repeat (8) tick();
    check("underflow_count", test_pops, 32'd3);
    check("underflow_valid_low", {31'd0, s_valid}, 32'd0);

    // Reset mid-stream with the buffer full, then count from zero again.
    for (int i = 0; i < 8; i++) push_word(DW'(8'h20 + i));
    m_ready = 1'b0;
    repeat (4) tick();
    check("full_before_reset", {31'd0, s_valid}, 32'd1);
    do_reset(1);
    tick();
    check("after_reset_valid", {31'd0, s_valid}, 32'd0);
    test_pops = 0;
    for (int i = 0; i < 9; i++) push_word(DW'(8'h40 + i));
    drain(60);
    check("post_reset_count", test_pops, 32'd9);
`ifdef FIFO_RD_STREAM_COUNT_EN
    check("count_wrap", {29'd0, rd_beat_count}, 32'd1);
`endif

    // Random producer and consumer against the queue model.
    test_pops = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(1, 0) == 1 && src_q.size() < 20) push_word(DW'($urandom));
      m_ready = ($urandom_range(3, 0) != 0);
      tick();
    end
    drain(200);
    check("random_idle_valid", {31'd0, m_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
